mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 13 +
 rtl/rr_arb2.sv | 48 ++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter.
// Both ports share one single-ported synchronous RAM.
package mem_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      RDWAIT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter with a one-bit last-grant pointer.
// Supports round-robin mode and fixed port-0 priority mode.
module rr_arb2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic last;

   // Pick a winner; on contention the port that did not win last goes first.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
               gnt0 = 1'b1;
            end else if (last) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // Remember the last granted port; reset value lets port 0 win first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (gnt0) begin
         last <= 1'b0;
      end else if (gnt1) begin
         last <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous RAM.
// Writes complete in one cycle; reads return data one cycle later.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              wrEn,
   output logic [ADDR_W-1:0] addr_toRAM,
   output logic [DATA_W-1:0] data_toRAM,
   input  logic [DATA_W-1:0] data_fromRAM
);

   state_t state, state_n;
   logic   rec, rec_n;
   logic   arb_en;
   logic   g0, g1;
   logic   sel;
   logic   wr;

   assign arb_en = rst && (state == IDLE);
   assign sel    = g1;
   assign wr     = sel ? we1 : we0;

   rr_arb2 #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en),
      .req0(req0),
      .req1(req1),
      .gnt0(g0),
      .gnt1(g1)
   );

   // State and recorded read port; reset aborts any pending read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rec   <= 1'b0;
      end else begin
         state <= state_n;
         rec   <= rec_n;
      end
   end

   // Next state and all outputs; everything idles low while in reset.
   always_comb begin
      state_n    = state;
      rec_n      = rec;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      rvalid0    = 1'b0;
      rvalid1    = 1'b0;
      rdata      = '0;
      wrEn       = 1'b0;
      addr_toRAM = '0;
      data_toRAM = '0;
      if (rst) begin
         unique case (state)
            IDLE: begin
               if (g0 || g1) begin
                  gnt0       = g0;
                  gnt1       = g1;
                  wrEn       = wr;
                  addr_toRAM = sel ? addr1 : addr0;
                  if (wr) begin
                     data_toRAM = sel ? wdata1 : wdata0;
                  end else begin
                     state_n = RDWAIT;
                     rec_n   = sel;
                  end
               end
            end
            RDWAIT: begin
               rvalid0 = !rec;
               rvalid1 = rec;
               rdata   = data_fromRAM;
               state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
// A second instance runs in fixed-priority mode on the same stimulus.
module tb_mem_arbiter;

   localparam int AW = 13;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1, wrEn;
   logic [DW-1:0] rdata, data_toRAM, data_fromRAM;
   logic [AW-1:0] addr_toRAM;

   logic          fg0, fg1, frv0, frv1, fwe;
   logic [DW-1:0] frd, fdo;
   logic [AW-1:0] fad;
   logic [DW-1:0] fdi;

   logic [DW-1:0] mem [256];

   int vecs;
   int errs;

   mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)
   ) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .wrEn(wrEn),
      .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
      .data_fromRAM(data_fromRAM)
   );

   mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)
   ) dut_fp (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(fg0), .gnt1(fg1),
      .rvalid0(frv0), .rvalid1(frv1),
      .rdata(frd), .wrEn(fwe),
      .addr_toRAM(fad), .data_toRAM(fdo),
      .data_fromRAM(fdi)
   );

   assign fdi = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: one-cycle read latency, preloaded word at address 3.
   always @(posedge clk) begin
      if (!rst) begin
         mem[3] <= 16'hBEEF;
      end else if (wrEn) begin
         mem[addr_toRAM[7:0]] <= data_toRAM;
      end
      data_fromRAM <= mem[addr_toRAM[7:0]];
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      req0   = 1'b0; req1   = 1'b0;
      we0    = 1'b0; we1    = 1'b0;
      addr0  = '0;   addr1  = '0;
      wdata0 = '0;   wdata1 = '0;
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      rst  = 1'b0;
      idle_in();

      // outputs held low during reset even with a live request
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 13'h5; wdata0 = 16'h1234;
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h9;
      #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_wren", 32'(wrEn), 32'd0);
      chk("rst_addr", 32'(addr_toRAM), 32'd0);
      chk("rst_data", 32'(data_toRAM), 32'd0);
      chk("rst_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
      idle_in();
      @(negedge clk);
      rst = 1'b1;

      // lone write from port 0
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 13'h5; wdata0 = 16'h1234;
      #1;
      chk("wr_gnt0", 32'(gnt0), 32'd1);
      chk("wr_gnt1", 32'(gnt1), 32'd0);
      chk("wr_wren", 32'(wrEn), 32'd1);
      chk("wr_addr", 32'(addr_toRAM), 32'h5);
      chk("wr_data", 32'(data_toRAM), 32'h1234);
      @(negedge clk);
      idle_in();
      #1;
      chk("wr_next_wren", 32'(wrEn), 32'd0);
      chk("wr_next_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("idle_rdata", 32'(rdata), 32'd0);

      // lone read from port 1 of preloaded word
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 13'h3;
      #1;
      chk("rd_gnt1", 32'(gnt1), 32'd1);
      chk("rd_wren", 32'(wrEn), 32'd0);
      chk("rd_addr", 32'(addr_toRAM), 32'h3);
      chk("rd_data0", 32'(data_toRAM), 32'd0);
      @(negedge clk);
      idle_in();
      #1;
      chk("rd_rv1", 32'(rvalid1), 32'd1);
      chk("rd_rv0", 32'(rvalid0), 32'd0);
      chk("rd_rdata", 32'(rdata), 32'hBEEF);
      chk("rd_nognt", {30'd0, gnt1, gnt0}, 32'd0);

      // port 0 reads back its write; port 1 held off during RDWAIT
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h5;
      #1;
      chk("ho_gnt0", 32'(gnt0), 32'd1);
      @(negedge clk);
      idle_in();
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h7; wdata1 = 16'h00AA;
      #1;
      chk("ho_gnt1_held", 32'(gnt1), 32'd0);
      chk("ho_rv0", 32'(rvalid0), 32'd1);
      chk("ho_rdata", 32'(rdata), 32'h1234);
      chk("ho_wren", 32'(wrEn), 32'd0);
      @(negedge clk);
      #1;
      chk("ho_gnt1", 32'(gnt1), 32'd1);
      chk("ho_rv0_once", 32'(rvalid0), 32'd0);
      chk("ho_addr", 32'(addr_toRAM), 32'h7);
      chk("ho_data", 32'(data_toRAM), 32'h00AA);

      // continuous contention: alternating grants, fixed mode always port 0
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 13'h10; wdata0 = 16'h0001;
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h20; wdata1 = 16'h0002;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cn_gnt0", 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("cn_gnt1", 32'(gnt1), (i % 2 == 1) ? 32'd1 : 32'd0);
         chk("cn_addr", 32'(addr_toRAM),
             (i % 2 == 0) ? 32'h10 : 32'h20);
         chk("fp_gnt0", 32'(fg0), 32'd1);
         chk("fp_gnt1", 32'(fg1), 32'd0);
         @(negedge clk);
      end
      idle_in();

      // reset during RDWAIT, pointer left at 0 beforehand
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h3;
      #1;
      chk("rr_gnt0", 32'(gnt0), 32'd1);
      @(negedge clk);
      idle_in();
      #1;
      chk("rr_pre_rv0", 32'(rvalid0), 32'd1);
      rst = 1'b0;
      #1;
      chk("rr_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("rr_rdata", 32'(rdata), 32'd0);
      chk("rr_fp_rv", {30'd0, frv1, frv0}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 13'h1; wdata0 = 16'h0011;
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h2; wdata1 = 16'h0022;
      #1;
      chk("rr_first_gnt0", 32'(gnt0), 32'd1);
      chk("rr_first_gnt1", 32'(gnt1), 32'd0);
      chk("rr_first_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
      @(negedge clk);
      idle_in();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
